// File: rtl/timer_unit_param_if.sv
// Register-level bus of the prescaled timer/compare unit: controls, compare values and flag/IRQ status.
interface timer_unit_param_if #(
   parameter int WIDTH   = 16,
   parameter int NUM_CMP = 2
);
   logic [2:0]               clk_sel;
   logic                     mode;
   logic                     TCNT_write_enable;
   logic [WIDTH-1:0]         TCNT_input;
   logic [NUM_CMP*WIDTH-1:0] OCR_input;
   logic [NUM_CMP:0]         flag_clear;
   logic [NUM_CMP:0]         int_mask;
   logic [WIDTH-1:0]         TCNT_output;
   logic [NUM_CMP:0]         TIFR_output;
   logic                     TIFR_write_enable;
   logic                     irq;

   modport master (
      output clk_sel, mode, TCNT_write_enable, TCNT_input, OCR_input, flag_clear, int_mask,
      input  TCNT_output, TIFR_output, TIFR_write_enable, irq
   );

   modport slave (
      input  clk_sel, mode, TCNT_write_enable, TCNT_input, OCR_input, flag_clear, int_mask,
      output TCNT_output, TIFR_output, TIFR_write_enable, irq
   );
endinterface

// File: rtl/timer_unit_param.sv
// Prescaled up-counter with normal/CTC modes, NUM_CMP output-compare channels and sticky
// overflow/compare flags; channel 0 doubles as the CTC top value.
module timer_unit_param #(
   parameter int WIDTH   = 16,
   parameter int NUM_CMP = 2
) (
   input logic               sysClock,
   input logic               reset,
   timer_unit_param_if.slave bus
);
   localparam int PW = 10;

   logic [PW-1:0]    presc_q, presc_d, presc_last;
   logic [2:0]       sel_q;
   logic             sel_valid, sel_changed, tick;
   logic [WIDTH-1:0] tcnt_q, tcnt_d, ocr0;
   logic [NUM_CMP:0] flags_q, flags_d, set_v;
   logic             tifr_we_q, tifr_we_d;

   // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
   always_comb begin
      sel_valid  = 1'b1;
      presc_last = '0;
      case (bus.clk_sel)
         3'd1:    presc_last = 10'd0;
         3'd2:    presc_last = 10'd7;
         3'd3:    presc_last = 10'd63;
         3'd4:    presc_last = 10'd255;
         3'd5:    presc_last = 10'd1023;
         default: sel_valid  = 1'b0;
      endcase
   end

   // A select change (including the first cycle after reset) restarts a full prescaler period.
   assign sel_changed = (bus.clk_sel != sel_q);
   assign tick = sel_valid && !sel_changed && !bus.TCNT_write_enable && (presc_q == presc_last);

   always_comb begin
      presc_d = presc_q + 1'b1;
      if (!sel_valid || sel_changed || bus.TCNT_write_enable || tick) begin
         presc_d = '0;
      end
   end

   assign ocr0 = bus.OCR_input[WIDTH-1:0];

   always_comb begin
      tcnt_d = tcnt_q;
      set_v  = '0;
      if (bus.TCNT_write_enable) begin
         tcnt_d = bus.TCNT_input;
      end else if (tick) begin
         // Compares use the pre-update count, so the flag lands on the edge that leaves the value.
         for (int n = 0; n < NUM_CMP; n++) begin
            if (bus.OCR_input[n*WIDTH +: WIDTH] == tcnt_q) begin
               set_v[n+1] = 1'b1;
            end
         end
         if (bus.mode && (tcnt_q == ocr0)) begin
            tcnt_d = '0;
         end else begin
            tcnt_d   = tcnt_q + 1'b1;
            set_v[0] = &tcnt_q;
         end
      end
      flags_d   = (flags_q & ~bus.flag_clear) | set_v;
      tifr_we_d = |(set_v & ~flags_q);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysClock) begin
      if (reset) begin
         presc_q   <= '0;
         sel_q     <= 3'd0;
         tcnt_q    <= '0;
         flags_q   <= '0;
         tifr_we_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         sel_q     <= bus.clk_sel;
         tcnt_q    <= tcnt_d;
         flags_q   <= flags_d;
         tifr_we_q <= tifr_we_d;
      end
   end

   assign bus.TCNT_output       = tcnt_q;
   assign bus.TIFR_output       = flags_q;
   assign bus.TIFR_write_enable = tifr_we_q;
   assign bus.irq               = |(flags_q & bus.int_mask);
endmodule

// File: tb/tb_timer_unit_param.sv
// Bench for timer_unit_param: reset, a per-cycle vector table, hand-written corner sequences
// and a randomized run against a cycle-level reference model.
module tb_timer_unit_param;
   localparam int WIDTH   = 16;
   localparam int NUM_CMP = 2;

   logic sysClock = 1'b0;
   logic reset;

   timer_unit_param_if #(.WIDTH(WIDTH), .NUM_CMP(NUM_CMP)) bus ();

   timer_unit_param #(.WIDTH(WIDTH), .NUM_CMP(NUM_CMP)) dut (
      .sysClock (sysClock),
      .reset    (reset),
      .bus      (bus.slave)
   );

   always #5 sysClock = ~sysClock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge sysClock);
      #1;
   endtask

   task automatic check_all(input string name, input logic [15:0] e_tcnt, input logic [2:0] e_tifr,
                            input logic e_we, input logic e_irq);
      check({name, ".tcnt"}, bus.TCNT_output, e_tcnt);
      check({name, ".tifr"}, bus.TIFR_output, e_tifr);
      check({name, ".we"},   bus.TIFR_write_enable, e_we);
      check({name, ".irq"},  bus.irq, e_irq);
   endtask

   typedef struct {
      logic [2:0]  sel;
      logic        mode;
      logic        wr;
      logic [15:0] tin;
      logic [15:0] ocr1;
      logic [2:0]  clr;
      logic [2:0]  mask;
      logic [15:0] e_tcnt;
      logic [2:0]  e_tifr;
      logic        e_we;
      logic        e_irq;
   } vec_t;

   vec_t vecs[14];

   // Reference model state: plain integers updated from the rules of each cycle.
   int         m_cnt, m_presc, m_prev_sel;
   logic [2:0] m_flags;
   logic       m_we;

   function automatic int divisor(input int s);
      case (s)
         1: return 1;
         2: return 8;
         3: return 64;
         4: return 256;
         5: return 1024;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int         d;
      bit         tk;
      logic [2:0] setv;
      logic [2:0] newf;
      int         ocr_ch[NUM_CMP];
      if (reset) begin
         m_cnt = 0; m_presc = 0; m_prev_sel = 0; m_flags = '0; m_we = 1'b0;
         return;
      end
      for (int n = 0; n < NUM_CMP; n++) ocr_ch[n] = int'(bus.OCR_input[n*WIDTH +: WIDTH]);
      d    = divisor(int'(bus.clk_sel));
      tk   = (d != 0) && (int'(bus.clk_sel) == m_prev_sel) && !bus.TCNT_write_enable && (m_presc == d - 1);
      setv = '0;
      if (d == 0 || int'(bus.clk_sel) != m_prev_sel || bus.TCNT_write_enable || tk) m_presc = 0;
      else m_presc = m_presc + 1;
      m_prev_sel = int'(bus.clk_sel);
      if (bus.TCNT_write_enable) begin
         m_cnt = int'(bus.TCNT_input);
      end else if (tk) begin
         for (int n = 0; n < NUM_CMP; n++) if (ocr_ch[n] == m_cnt) setv[n+1] = 1'b1;
         if (bus.mode && m_cnt == ocr_ch[0]) begin
            m_cnt = 0;
         end else begin
            if (m_cnt == (1 << WIDTH) - 1) setv[0] = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << WIDTH);
         end
      end
      newf    = (m_flags & ~bus.flag_clear) | setv;
      m_we    = |(newf & ~m_flags);
      m_flags = newf;
   endtask

   initial begin
      int exp_seq[6];
      // Per-cycle vectors at /1: wrap with TOV, masked irq, clear, OCF1 match, stop and restart.
      vecs[0]  = '{3'd1, 1'b0, 1'b1, 16'hFFFE, 16'h0200, 3'b000, 3'b000, 16'hFFFE, 3'b000, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0200, 3'b000, 3'b000, 16'hFFFF, 3'b000, 1'b0, 1'b0};
      vecs[2]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0200, 3'b000, 3'b000, 16'h0000, 3'b001, 1'b1, 1'b0};
      vecs[3]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0200, 3'b000, 3'b000, 16'h0001, 3'b001, 1'b0, 1'b0};
      vecs[4]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0200, 3'b000, 3'b001, 16'h0002, 3'b001, 1'b0, 1'b1};
      vecs[5]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0200, 3'b001, 3'b001, 16'h0003, 3'b000, 1'b0, 1'b0};
      vecs[6]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0004, 3'b000, 1'b0, 1'b0};
      vecs[7]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0005, 3'b000, 1'b0, 1'b0};
      vecs[8]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0006, 3'b100, 1'b1, 1'b1};
      vecs[9]  = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b100, 3'b100, 16'h0007, 3'b000, 1'b0, 1'b0};
      vecs[10] = '{3'd0, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0007, 3'b000, 1'b0, 1'b0};
      vecs[11] = '{3'd0, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0007, 3'b000, 1'b0, 1'b0};
      vecs[12] = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0007, 3'b000, 1'b0, 1'b0};
      vecs[13] = '{3'd1, 1'b0, 1'b0, 16'h0000, 16'h0005, 3'b000, 3'b100, 16'h0008, 3'b000, 1'b0, 1'b0};

      // Reset must override a preload and a running /1 prescaler.
      reset = 1'b1;
      bus.clk_sel = 3'd1; bus.mode = 1'b0; bus.TCNT_write_enable = 1'b1; bus.TCNT_input = 16'hFFFF;
      bus.OCR_input = {16'h0200, 16'h0100}; bus.flag_clear = '0; bus.int_mask = 3'b111;
      repeat (3) step();
      check_all("reset", 16'h0000, 3'b000, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         bus.clk_sel = vecs[i].sel; bus.mode = vecs[i].mode; bus.TCNT_write_enable = vecs[i].wr;
         bus.TCNT_input = vecs[i].tin; bus.OCR_input = {vecs[i].ocr1, 16'h0100};
         bus.flag_clear = vecs[i].clr; bus.int_mask = vecs[i].mask;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_tcnt, vecs[i].e_tifr, vecs[i].e_we, vecs[i].e_irq);
      end

      // CTC at /8 with OCR0=4: 0..4,0 with 8 cycles per value, OCF0 on the 4->0 edge, no TOV.
      bus.mode = 1'b1; bus.OCR_input = {16'h0200, 16'h0004}; bus.clk_sel = 3'd2;
      bus.TCNT_write_enable = 1'b1; bus.TCNT_input = 16'h0000; bus.flag_clear = 3'b111; bus.int_mask = '0;
      step();
      bus.TCNT_write_enable = 1'b0; bus.flag_clear = '0;
      exp_seq = '{0, 1, 2, 3, 4, 0};
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 8; j++) begin
            check($sformatf("ctc8.tcnt[%0d.%0d]", k, j), bus.TCNT_output, exp_seq[k]);
            check($sformatf("ctc8.tifr[%0d.%0d]", k, j), bus.TIFR_output, (k == 5) ? 3'b010 : 3'b000);
            check($sformatf("ctc8.we[%0d.%0d]", k, j), bus.TIFR_write_enable, (k == 5 && j == 0));
            step();
         end
      end
      check("ctc8.after", bus.TIFR_output, 3'b010);

      // OCR0=10, OCR1=5, irq only from OCF1.
      bus.OCR_input = {16'h0005, 16'h000A}; bus.clk_sel = 3'd1; bus.int_mask = 3'b100;
      bus.TCNT_write_enable = 1'b1; bus.TCNT_input = 16'h0000; bus.flag_clear = 3'b111;
      step();
      bus.TCNT_write_enable = 1'b0; bus.flag_clear = '0;
      repeat (6) step();
      check_all("ocf1_set", 16'h0006, 3'b100, 1'b1, 1'b1);
      bus.flag_clear = 3'b100;
      step();
      bus.flag_clear = '0;
      check_all("ocf1_clr", 16'h0007, 3'b000, 1'b0, 1'b0);

      // Clear of OCF0 on the very edge it is set: set wins.
      repeat (3) step();
      check("pre_match.tcnt", bus.TCNT_output, 16'h000A);
      bus.flag_clear = 3'b010;
      step();
      bus.flag_clear = '0;
      check_all("set_wins", 16'h0000, 3'b010, 1'b1, 1'b0);

      // Preload on a tick cycle where TCNT==OCR1: load wins, no OCF1.
      repeat (5) step();
      check("pre_load.tcnt", bus.TCNT_output, 16'h0005);
      bus.TCNT_write_enable = 1'b1; bus.TCNT_input = 16'h1234;
      step();
      bus.TCNT_write_enable = 1'b0;
      check_all("load_on_match", 16'h1234, 3'b010, 1'b0, 1'b0);
      step();
      check("load_then_count", bus.TCNT_output, 16'h1235);

      // One-cycle reset mid-count with flags set; /1 restarts on the second edge after release.
      bus.int_mask = 3'b111;
      bus.TCNT_write_enable = 1'b1; bus.TCNT_input = 16'h0100;
      step();
      bus.TCNT_write_enable = 1'b0;
      check("pre_reset.tcnt", bus.TCNT_output, 16'h0100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all("mid_reset", 16'h0000, 3'b000, 1'b0, 1'b0);
      step();
      check("post_reset.e1", bus.TCNT_output, 16'h0000);
      step();
      check("post_reset.e2", bus.TCNT_output, 16'h0001);

      // Randomized run against the reference model.
      reset = 1'b1;
      model_step();
      step();
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 63) == 0)
            bus.clk_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
         if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
         if ($urandom_range(0, 19) == 0)
            bus.OCR_input = {16'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(2, 9))};
         bus.TCNT_write_enable = ($urandom_range(0, 24) == 0);
         bus.TCNT_input = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'hFFF8 + 16'($urandom_range(0, 7));
         bus.flag_clear = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         if ($urandom_range(0, 15) == 0) bus.int_mask = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 299) == 0);
         model_step();
         step();
         check("rnd.tcnt", bus.TCNT_output, m_cnt);
         check("rnd.tifr", bus.TIFR_output, m_flags);
         check("rnd.we",   bus.TIFR_write_enable, m_we);
         check("rnd.irq",  bus.irq, |(m_flags & bus.int_mask));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/timer_unit_param.md
TIMER_UNIT_PARAM -- requirements
Module: timer_unit_param

Interface
- REQ-001: Parameter WIDTH, default 16: counter and compare-register width in bits, legal range 8..32.
- REQ-002: Parameter NUM_CMP, default 2: number of output-compare channels, legal range 1..4; channel 0 is the CTC TOP channel.
- REQ-003: sysClock  in  1: sole clock; all state SHALL update on its rising edge.
- REQ-004: reset  in  1: synchronous, active-high reset.
- REQ-005: clk_sel  in  3: prescaler select. 0=stopped, 1=/1, 2=/8, 3=/64, 4=/256, 5=/1024, 6-7=stopped.
- REQ-006: mode  in  1: 0=normal (free-run wrap), 1=CTC (clear on channel-0 match).
- REQ-007: TCNT_write_enable  in  1: preload strobe.
- REQ-008: TCNT_input  in  WIDTH: preload value.
- REQ-009: OCR_input  in  NUM_CMP*WIDTH: compare values; channel n occupies bits [n*WIDTH +: WIDTH].
- REQ-010: flag_clear  in  NUM_CMP+1: write-1-to-clear mask, same bit map as TIFR_output.
- REQ-011: int_mask  in  NUM_CMP+1: interrupt enable per flag.
- REQ-012: TCNT_output  out  WIDTH: current count, registered.
- REQ-013: TIFR_output  out  NUM_CMP+1: flags; bit0=TOV, bit n+1=OCF of channel n; registered.
- REQ-014: TIFR_write_enable  out  1: high for one cycle whenever any flag bit transitions 0->1.
- REQ-015: irq  out  1: OR of (TIFR_output & int_mask), combinational from registered flags.

Function
- REQ-016: A 10-bit prescaler counter SHALL increment every cycle while clk_sel selects a divisor N, and SHALL assert an internal tick for exactly one cycle when it equals N-1, then return to 0; for /1, tick SHALL be high every cycle.
- REQ-017: While clk_sel is 0, 6 or 7, the prescaler SHALL hold at 0 and no tick SHALL occur.
- REQ-018: The prescaler SHALL return to 0 on reset, on TCNT_write_enable, and in the cycle following any change of clk_sel.
- REQ-019: On a tick in normal mode, TCNT SHALL increment modulo 2^WIDTH; the transition from all-ones to 0 SHALL set TOV.
- REQ-020: On a tick in CTC mode with TCNT == OCR channel 0, TCNT SHALL load 0 and TOV SHALL NOT be set; otherwise TCNT follows REQ-019, including the all-ones wrap and TOV.
- REQ-021: On a tick, every channel n whose OCR equals the pre-update TCNT SHALL set OCF(n+1) on the same edge that updates TCNT.
- REQ-022: Matches are evaluated only on ticks; a TCNT value held across several non-tick cycles SHALL set its flag once.
- REQ-023: TCNT_write_enable SHALL load TCNT_input on the next edge, suppress that cycle's tick, and set no flags.
- REQ-024: A flag bit with flag_clear high SHALL clear on the next edge, unless the same edge sets it; set wins.
- REQ-025: TIFR_write_enable SHALL be registered and high in the cycle TIFR_output first shows the newly set bit.
- REQ-026: Changes of OCR_input or mode SHALL take effect at the next tick with no internal buffering.
- REQ-027: Flags SHALL be sticky until cleared; a repeated set of an already-set bit SHALL NOT pulse TIFR_write_enable.

Reset
- REQ-028: While reset is high, TCNT_output=0, TIFR_output=0, TIFR_write_enable=0, irq=0 and prescaler=0; reset SHALL override preload, tick and clear.
- REQ-029: A reset asserted mid-count SHALL take effect on the next edge; after release, counting restarts from 0 with a full prescaler period.

Verification
- REQ-030: WIDTH=16, clk_sel=1, mode=0, preload 0xFFFE -> TCNT 0xFFFF, then 0x0000; TOV=1 and TIFR_write_enable pulses once, on the 0x0000 cycle.
- REQ-031: mode=1, OCR0=4, clk_sel=2 (/8) -> TCNT sequence 0,1,2,3,4,0 with 8 sysClock cycles per step; OCF0 sets on the 4->0 edge; TOV stays 0.
- REQ-032: OCR0=10, OCR1=5, mode=1, int_mask=3'b100 -> OCF1 sets at TCNT 5->6 and irq=1; then flag_clear=3'b100 -> OCF1=0, irq=0 next cycle.
- REQ-033: flag_clear on OCF0 in the same cycle as a channel-0 match -> OCF0 remains 1.
- REQ-034: TCNT_write_enable with TCNT_input=0x1234 on a tick cycle where TCNT==OCR1 -> TCNT=0x1234, OCF1 unchanged, prescaler restarts.
- REQ-035: reset pulsed for 1 cycle at TCNT=0x0100 with flags set -> all outputs 0 on the next cycle; with /1, the first increment occurs on the second edge after release.
